mem_port_arbiter: RTL and testbench

//  Shares the single processor memory port among three requesters:
//   - commit-stage stores (st)
//   - load-buffer reads (ld)
//   - instruction fetch (if)

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_owner_table.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the processor memory-port arbiter: bus commands, tag owners, grants.
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LD = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'h0,
        GNT_ST   = 2'h1,
        GNT_LD   = 2'h2,
        GNT_IF   = 2'h3
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter_owner_table.sv
// Per-tag owner record: which requester issued each outstanding load tag.
module mem_tag_owner_table
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W = MEM_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  owner_e           alloc_owner,
    input  logic [TAG_W-1:0] ret_tag,
    output logic             ret_hit,
    output owner_e           ret_owner
);

    localparam int unsigned N_TAGS = 2 ** TAG_W;

    logic [N_TAGS-1:0] own_v;
    logic [N_TAGS-1:0] own_is_ld;

    assign ret_hit   = (ret_tag != '0) && own_v[ret_tag];
    assign ret_owner = own_is_ld[ret_tag] ? OWN_LD : OWN_IF;

    // Allocation is written after the clear so a tag returned and reissued
    // in the same cycle ends valid with its new owner.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            own_v     <= '0;
            own_is_ld <= '0;
        end else begin
            if (ret_hit)
                own_v[ret_tag] <= 1'b0;
            if (alloc_en) begin
                own_v[alloc_tag]     <= 1'b1;
                own_is_ld[alloc_tag] <= (alloc_owner == OWN_LD);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Per-cycle arbitration of the memory port among stores, load buffer and fetch,
// with fetch starvation protection and tag-based return routing.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned TAG_W        = MEM_TAG_W,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_LD_OUT   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [TAG_W-1:0]  mem2proc_tag,
    input  logic [DATA_W-1:0] mem2proc_data,
    output logic [1:0]        proc2mem_command,
    output logic [ADDR_W-1:0] proc2mem_addr,
    output logic [DATA_W-1:0] proc2mem_data,
    output logic              st_done,
    output logic              ld_accept,
    output logic              if_accept,
    output logic              ld_rdata_valid,
    output logic              if_rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic [TAG_W-1:0]  ld_tag_out,
    output logic              if_blocked
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LW = $clog2(MAX_LD_OUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LD_MAX     = LW'(MAX_LD_OUT);

    logic [SW-1:0] starve_cnt;
    logic [LW-1:0] ld_out;
    grant_e        grant;
    bus_command_e  cmd;
    logic          accepted;
    logic          ret_hit;
    owner_e        ret_owner;

    always_comb begin
        grant = GNT_NONE;
        if (if_req && starve_cnt == STARVE_MAX)
            grant = GNT_IF;
        else if (st_req)
            grant = GNT_ST;
        else if (ld_req && ld_out < LD_MAX)
            grant = GNT_LD;
        else if (if_req)
            grant = GNT_IF;
    end

    assign accepted = (mem2proc_response != '0);

    always_comb begin
        cmd           = BUS_NONE;
        proc2mem_addr = '0;
        proc2mem_data = '0;
        if (reset) begin
            unique case (grant)
                GNT_ST: begin
                    cmd           = BUS_STORE;
                    proc2mem_addr = st_addr;
                    proc2mem_data = st_data;
                end
                GNT_LD: begin
                    cmd           = BUS_LOAD;
                    proc2mem_addr = ld_addr;
                end
                GNT_IF: begin
                    cmd           = BUS_LOAD;
                    proc2mem_addr = if_addr;
                end
                default: ;
            endcase
        end
    end

    assign proc2mem_command = cmd;

    assign st_done   = reset && accepted && (grant == GNT_ST);
    assign ld_accept = reset && accepted && (grant == GNT_LD);
    assign if_accept = reset && accepted && (grant == GNT_IF);
    assign if_blocked = reset && if_req && !if_accept;

    mem_tag_owner_table #(
        .TAG_W (TAG_W)
    ) u_owner_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (ld_accept || if_accept),
        .alloc_tag   (mem2proc_response),
        .alloc_owner (ld_accept ? OWN_LD : OWN_IF),
        .ret_tag     (mem2proc_tag),
        .ret_hit     (ret_hit),
        .ret_owner   (ret_owner)
    );

    assign ld_rdata_valid = reset && ret_hit && (ret_owner == OWN_LD);
    assign if_rdata_valid = reset && ret_hit && (ret_owner == OWN_IF);
    assign rdata          = reset ? mem2proc_data : '0;

    // A new load accept takes the tag output over a same-cycle load return.
    assign ld_tag_out = ld_accept      ? mem2proc_response :
                        ld_rdata_valid ? mem2proc_tag      : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            ld_out     <= '0;
        end else begin
            unique case ({ld_accept, ld_rdata_valid})
                2'b10:   ld_out <= ld_out + 1'b1;
                2'b01:   ld_out <= ld_out - 1'b1;
                default: ;
            endcase
            if (!if_req || if_accept)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a per-cycle reference model of the port rules.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        st_req, ld_req, if_req;
    logic [63:0] st_addr, st_data, ld_addr, if_addr;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr, proc2mem_data, rdata;
    logic        st_done, ld_accept, if_accept, ld_rdata_valid, if_rdata_valid, if_blocked;
    logic [3:0]  ld_tag_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: owner per tag (0 none, 1 load buffer, 2 fetch), counters as ints
    int owner [16];
    int m_ldout = 0;
    int m_starve = 0;

    mem_port_arbiter #(
        .ADDR_W       (64),
        .DATA_W       (64),
        .TAG_W        (4),
        .STARVE_LIMIT (4),
        .MAX_LD_OUT   (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .st_req            (st_req),
        .st_addr           (st_addr),
        .st_data           (st_data),
        .ld_req            (ld_req),
        .ld_addr           (ld_addr),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .mem2proc_response (mem2proc_response),
        .mem2proc_tag      (mem2proc_tag),
        .mem2proc_data     (mem2proc_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .st_done           (st_done),
        .ld_accept         (ld_accept),
        .if_accept         (if_accept),
        .ld_rdata_valid    (ld_rdata_valid),
        .if_rdata_valid    (if_rdata_valid),
        .rdata             (rdata),
        .ld_tag_out        (ld_tag_out),
        .if_blocked        (if_blocked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs from current inputs, then state advance
    int          win, ret_own;
    logic        e_acc, e_st, e_ld, e_if, e_lrv, e_irv, e_blk;
    logic [1:0]  e_cmd;
    logic [63:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_ltag;

    always @(negedge clock) begin
        if (!reset) begin
            foreach (owner[i]) owner[i] = 0;
            m_ldout = 0;
            m_starve = 0;
            e_cmd = 2'd0; e_addr = '0; e_wdata = '0; e_st = 0; e_ld = 0; e_if = 0;
            e_lrv = 0; e_irv = 0; e_rdata = '0; e_ltag = '0; e_blk = 0;
        end else begin
            win = 0;
            if (if_req && m_starve == 4) win = 3;
            else if (st_req) win = 1;
            else if (ld_req && m_ldout < 8) win = 2;
            else if (if_req) win = 3;
            e_acc   = (mem2proc_response != 0);
            e_cmd   = (win == 0) ? 2'd0 : (win == 1) ? 2'd2 : 2'd1;
            e_addr  = (win == 1) ? st_addr : (win == 2) ? ld_addr : (win == 3) ? if_addr : 64'd0;
            e_wdata = (win == 1) ? st_data : 64'd0;
            e_st    = (win == 1) && e_acc;
            e_ld    = (win == 2) && e_acc;
            e_if    = (win == 3) && e_acc;
            ret_own = (mem2proc_tag != 0) ? owner[mem2proc_tag] : 0;
            e_lrv   = (ret_own == 1);
            e_irv   = (ret_own == 2);
            e_rdata = mem2proc_data;
            e_ltag  = e_ld ? mem2proc_response : e_lrv ? mem2proc_tag : 4'd0;
            e_blk   = if_req && !e_if;
        end
        chk("command", 64'(proc2mem_command), 64'(e_cmd));
        chk("addr", proc2mem_addr, e_addr);
        chk("wdata", proc2mem_data, e_wdata);
        chk("st_done", 64'(st_done), 64'(e_st));
        chk("ld_accept", 64'(ld_accept), 64'(e_ld));
        chk("if_accept", 64'(if_accept), 64'(e_if));
        chk("ld_rdata_valid", 64'(ld_rdata_valid), 64'(e_lrv));
        chk("if_rdata_valid", 64'(if_rdata_valid), 64'(e_irv));
        chk("rdata", rdata, e_rdata);
        chk("ld_tag_out", 64'(ld_tag_out), 64'(e_ltag));
        chk("if_blocked", 64'(if_blocked), 64'(e_blk));
        if (reset) begin
            if (ret_own != 0) begin
                owner[mem2proc_tag] = 0;
                if (ret_own == 1) m_ldout--;
            end
            if (e_ld) begin
                owner[mem2proc_response] = 1;
                m_ldout++;
            end
            if (e_if) owner[mem2proc_response] = 2;
            if (!if_req || e_if) m_starve = 0;
            else if (m_starve < 4) m_starve++;
        end
    end

    task automatic set_in(input logic s, input logic l, input logic f,
                          input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] d);
        st_req = s; ld_req = l; if_req = f;
        mem2proc_response = resp; mem2proc_tag = tag; mem2proc_data = d;
        #1;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        st_addr = 64'h0000_0000_0000_1000;
        st_data = 64'h5A5A_0000_1234_5678;
        ld_addr = 64'h0000_0000_0000_2000;
        if_addr = 64'h0000_0000_0000_3000;

        // Requests during reset: everything must read 0
        set_in(1, 1, 1, 4'd3, 4'd0, 64'hFF);
        chk("rst_command", 64'(proc2mem_command), 64'd0);
        chk("rst_st_done", 64'(st_done), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        tick;
        tick;
        reset = 1'b1;

        // 1. idle after reset
        set_in(0, 0, 0, 4'd0, 4'd0, 64'd0);
        chk("t1_command", 64'(proc2mem_command), 64'd0);
        chk("t1_accepts", 64'({st_done, ld_accept, if_accept}), 64'd0);
        chk("t1_rvalid", 64'({ld_rdata_valid, if_rdata_valid}), 64'd0);
        tick;

        // 2. all three request; store wins
        set_in(1, 1, 1, 4'd3, 4'd0, 64'd0);
        chk("t2_command", 64'(proc2mem_command), 64'd2);
        chk("t2_st_done", 64'(st_done), 64'd1);
        chk("t2_ld_if_acc", 64'({ld_accept, if_accept}), 64'd0);
        chk("t2_if_blocked", 64'(if_blocked), 64'd1);
        chk("t2_wdata", proc2mem_data, 64'h5A5A_0000_1234_5678);
        tick;
        set_in(0, 0, 0, 4'd0, 4'd0, 64'd0);
        tick;

        // 3. fetch starves under continuous stores, forced on the fifth cycle
        for (int i = 1; i <= 5; i++) begin
            set_in(1, 0, 1, 4'd1, 4'd0, 64'd0);
            if (i < 5) begin
                chk("t3_st_done", 64'(st_done), 64'd1);
                chk("t3_if_acc", 64'(if_accept), 64'd0);
            end else begin
                chk("t3_forced_if", 64'(if_accept), 64'd1);
                chk("t3_forced_st", 64'(st_done), 64'd0);
                chk("t3_forced_addr", proc2mem_addr, 64'h3000);
            end
            tick;
        end
        set_in(1, 0, 1, 4'd1, 4'd0, 64'd0);
        chk("t3_after_st", 64'(st_done), 64'd1);
        tick;
        set_in(0, 0, 0, 4'd0, 4'd0, 64'd0);
        tick;

        // 4. load with tag 5 returns three cycles later
        set_in(0, 1, 0, 4'd5, 4'd0, 64'd0);
        chk("t4_ld_acc", 64'(ld_accept), 64'd1);
        chk("t4_ld_tag", 64'(ld_tag_out), 64'd5);
        tick;
        set_in(0, 0, 0, 4'd0, 4'd0, 64'd0);
        tick;
        tick;
        set_in(0, 0, 0, 4'd0, 4'd5, 64'hDEAD);
        chk("t4_ld_rv", 64'(ld_rdata_valid), 64'd1);
        chk("t4_rdata", rdata, 64'hDEAD);
        chk("t4_ret_tag", 64'(ld_tag_out), 64'd5);
        tick;
        set_in(0, 0, 0, 4'd0, 4'd5, 64'hBEEF);
        chk("t4_stale_tag", 64'({ld_rdata_valid, if_rdata_valid}), 64'd0);
        tick;

        // 5. fill the load buffer with tags 6..13, then fetch still wins
        for (int i = 0; i < 8; i++) begin
            set_in(0, 1, 0, 4'(6 + i), 4'd0, 64'd0);
            chk("t5_ld_acc", 64'(ld_accept), 64'd1);
            tick;
        end
        set_in(0, 1, 1, 4'd2, 4'd0, 64'd0);
        chk("t5_full_ld", 64'(ld_accept), 64'd0);
        chk("t5_full_if", 64'(if_accept), 64'd1);
        chk("t5_full_addr", proc2mem_addr, 64'h3000);
        tick;

        // 6. tag 7 returns to the load buffer while fetch reallocates it
        set_in(0, 0, 1, 4'd7, 4'd7, 64'h77);
        chk("t6_old_owner", 64'({ld_rdata_valid, if_rdata_valid}), 64'd2);
        chk("t6_if_acc", 64'(if_accept), 64'd1);
        chk("t6_ret_tag", 64'(ld_tag_out), 64'd7);
        tick;
        set_in(0, 1, 0, 4'd14, 4'd0, 64'd0);
        chk("t6_slot_freed", 64'(ld_accept), 64'd1);
        tick;
        set_in(0, 0, 0, 4'd0, 4'd1, 64'h11);
        chk("t6_if_rv", 64'(if_rdata_valid), 64'd1);
        tick;
        set_in(1, 1, 1, 4'd3, 4'd0, 64'd0);
        reset = 1'b0;
        #1;
        chk("t6_rst_st", 64'(st_done), 64'd0);
        tick;
        reset = 1'b1;
        set_in(0, 0, 0, 4'd0, 4'd7, 64'h99);
        chk("t6_post_rst", 64'({ld_rdata_valid, if_rdata_valid}), 64'd0);
        tick;
        set_in(0, 1, 0, 4'd3, 4'd0, 64'd0);
        chk("t6_ld_after_rst", 64'(ld_accept), 64'd1);
        tick;
        set_in(0, 0, 0, 4'd0, 4'd3, 64'h33);
        chk("t6_ld_ret_after_rst", 64'(ld_rdata_valid), 64'd1);
        tick;
        set_in(0, 0, 0, 4'd0, 4'd0, 64'd0);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
